lut_sequencer: RTL and testbench
================================

# lut_sequencer

Controller that sequences the per-symbol weight LUT (`lut_rom`) for one frame. On `start` it latches the symbol count N, drives it as the LUT address, and streams (symbol, weight) pairs for symbols 0..N-1 over a valid/ready interface. It also accumulates the total weight and reports it with a one-cycle `done` pulse. It sits between the frame-control logic and the downstream weight consumer (table builder), and instantiates `lut_rom` internally.

## Interface
- `ADDR_WIDTH`, default 4: width of N and of the symbol index. The `lut_rom` contents fix this at 4.
- `DATA_WIDTH`, default 6: weight width. The `lut_rom` contents fix this at 6.
- `SUM_WIDTH`, default 10: accumulator width. It must hold the maximum sum of 480.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  begin a frame. Sampled only in IDLE.
- `n_in`  in  ADDR_WIDTH  symbol count N, latched on the accepted `start`.
- `out_valid`  out  1  a weight beat is presented.
- `out_ready`  in  1  the consumer accepts the beat.
- `out_sym`  out  ADDR_WIDTH  symbol index of the current beat.
- `out_weight`  out  DATA_WIDTH  LUT output `q_<out_sym>` for the latched N.
- `out_last`  out  1  current beat is symbol N-1.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse at frame end.
- `sum_total`  out  SUM_WIDTH  sum of all weights transferred in the frame.

## Operation
- The FSM has three states: IDLE, RUN and DONE. Encoding is free.
- **IDLE:** `start` = 1 causes:
  - `n_reg` <= `n_in`, `sym` <= 0, `sum_total` <= 0.
  - If `n_in` != 0, go to RUN; otherwise go to DONE.
- **RUN:**
  - `out_valid` = 1.
  - `out_sym` = `sym`.
  - `out_weight` = mux of the `lut_rom` outputs selected by `sym`, with the LUT address = `n_reg`. This is combinational from registers and stable while stalled.
  - `out_last` = (`sym` == `n_reg` - 1).
- **Transfer** occurs when `out_valid` && `out_ready`:
  - `sum_total` <= `sum_total` + `out_weight`, zero-extended.
  - If `out_last` is set, go to DONE. Otherwise `sym` <= `sym` + 1.
- With `out_ready` = 0, the FSM holds every output and register.
- **DONE:** `done` = 1 for exactly one cycle, then go to IDLE.
- `sum_total` holds its value until the next accepted `start`.
- `start` is ignored in RUN and DONE; it is neither queued nor latched. `n_in` is ignored outside the accepted-start cycle.
- Expected weights are 4·(N-sym) for sym < N. Symbols ≥ N are never emitted.
- Arithmetic is unsigned with no overflow: the maximum `sum_total` is 4·120 = 480 at N = 15.

## Timing
- **Reset values:** state IDLE. `out_valid`, `out_last`, `busy` and `done` are 0. `out_sym`, `sum_total` and the internal `n_reg` are 0. `out_weight` follows the LUT with `n_reg` = 0, which gives 0.
- Reset asserted in any state forces the reset values on the next edge. A partial frame is discarded with no `done`.
- **Start latency:** `start` is sampled high in IDLE at edge t. `out_valid` rises after edge t, so beat 0 is presented in cycle t+1.
- **Throughput:** with `out_ready` held at 1, one beat per cycle. N beats occupy cycles t+1..t+N.
- **Frame end:**
  - `done` is high in cycle t+N+1, and `sum_total` is final in that same cycle.
  - IDLE is reached in cycle t+N+2, and a new `start` is accepted there.
- **N = 0:** `done` is high in cycle t+1, with no beats and `sum_total` = 0.
- **Ready before valid:** `out_ready` may be high before `out_valid`, and no transfer occurs while valid is low.
- **Valid after assertion:** once `out_valid` is asserted, it stays high until transfer.

## Test plan
- **Basic frame:** reset, then `start` with N = 3 and `out_ready` = 1.
  - Beats in cycles 1-3: (0,12), (1,8), (2,4).
  - `out_last` on the third beat only.
  - `done` in cycle 4 with `sum_total` = 24.
  - `busy` low in cycle 5.
- **Full frame:** N = 15 with ready always high.
  - 15 beats with weights 60, 56, …, 4.
  - `out_last` at sym 14.
  - `sum_total` = 480, with `done` 16 cycles after start.
- **Empty frame:** N = 0. No `out_valid` ever; `done` the cycle after start; `sum_total` = 0; IDLE two cycles after start.
- **Backpressure:** N = 4 with `out_ready` toggling 1,0,0,1,…
  - Outputs are held constant during stalls.
  - The beat order is (0,16), (1,12), (2,8), (3,4) with no drop or duplicate.
  - `sum_total` = 40.
- **Start while busy:**
  - During an N = 5 frame, pulse `start` with `n_in` = 2 at beat 2. The frame completes with 5 beats and sum 60, and nothing follows.
  - A second start in IDLE with N = 2 yields sum 12.
- **Reset mid-frame:**
  - Assert `rst` during beat 1 of an N = 6 frame. The next cycle shows all reset values, and no `done` is produced.
  - A following start with N = 1 yields a single beat (0,4), `out_last` = 1, and `sum_total` = 4.

Source files
------------

// File: rtl/lut_sequencer.sv
// lut_sequencer: streams (symbol, weight) pairs from a per-symbol weight LUT for one frame and totals the weights.
// Ports:
//    clk, rst            clock, synchronous active-high reset
//    start, n_in         begin a frame of n_in symbols (sampled in IDLE only)
//    out_valid/out_ready valid/ready handshake for each weight beat
//    out_sym, out_weight current symbol index and its LUT weight
//    out_last            current beat is symbol N-1
//    busy, done          frame in progress / one-cycle frame-end pulse
//    sum_total           sum of weights transferred in the current/last frame
module lut_rom #(
   parameter int AW = 4,
   parameter int DW = 6
) (
   input  logic [AW-1:0]                  addr_i,
   output logic [(1<<AW)-1:0][DW-1:0]     q_o
);
   // weight of symbol k for a frame of addr_i symbols is 4*(addr_i-k), zero beyond the frame
   always_comb
      for (int k = 0; k < (1 << AW); k++)
         q_o[k] = (k < int'(addr_i)) ? DW'(4 * (int'(addr_i) - k)) : '0;
endmodule

module lut_sequencer #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 6,
   parameter int SUM_WIDTH  = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] n_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDR_WIDTH-1:0] out_sym,
   output logic [DATA_WIDTH-1:0] out_weight,
   output logic                  out_last,
   output logic                  busy,
   output logic                  done,
   output logic [SUM_WIDTH-1:0]  sum_total
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t                                  state_q;
   logic [ADDR_WIDTH-1:0]                   n_q, sym_q;
   logic [SUM_WIDTH-1:0]                    sum_q;
   logic                                    valid_q, busy_q, done_q;
   logic [(1<<ADDR_WIDTH)-1:0][DATA_WIDTH-1:0] rom_q;
   logic                                    xfer;

   lut_rom #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH)) u_rom (.addr_i(n_q), .q_o(rom_q));

   assign out_valid  = valid_q;
   assign out_sym    = sym_q;
   assign out_weight = rom_q[sym_q];
   // gated by valid so last never shows outside RUN (n_q-1 wraps when n_q is 0)
   assign out_last   = valid_q && (sym_q == n_q - ADDR_WIDTH'(1));
   assign busy       = busy_q;
   assign done       = done_q;
   assign sum_total  = sum_q;
   assign xfer       = valid_q && out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         n_q     <= '0;
         sym_q   <= '0;
         sum_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (start) begin
               n_q     <= n_in;
               sym_q   <= '0;
               sum_q   <= '0;
               busy_q  <= 1'b1;
               valid_q <= n_in != '0;
               done_q  <= n_in == '0;
               state_q <= (n_in != '0) ? RUN : DONE;
            end
            RUN: if (xfer) begin
               sum_q <= sum_q + SUM_WIDTH'(out_weight);
               if (out_last) begin
                  valid_q <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else
                  sym_q <= sym_q + ADDR_WIDTH'(1);
            end
            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_lut_sequencer.sv
// tb_lut_sequencer: randomized self-checking bench for lut_sequencer against a symbol/weight model.
module tb_lut_sequencer;
   logic       clk = 0, rst = 1, start = 0, out_ready = 0;
   logic [3:0] n_in = 0;
   logic       out_valid, out_last, busy, done;
   logic [3:0] out_sym;
   logic [5:0] out_weight;
   logic [9:0] sum_total;
   int         n_checks = 0, n_fail = 0;

   lut_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .n_in(n_in),
      .out_valid(out_valid), .out_ready(out_ready), .out_sym(out_sym),
      .out_weight(out_weight), .out_last(out_last), .busy(busy),
      .done(done), .sum_total(sum_total)
   );

   always #5 clk = ~clk;

   // stall_mode: >=0 percent chance of ready low per cycle; <0 fixed 1,0,0 ready pattern
   task automatic run_frame(input int n, input int stall_mode, input bit pulse_start, input string name);
      int sym = 0, sum = 0, cyc = 0;
      bit fin = 0, pulsed = 0;
      logic [23:0] got, exp;
      logic [13:0] got_s, exp_s;
      @(negedge clk);
      start = 1; n_in = 4'(n); out_ready = 1;
      @(negedge clk);
      start = 0; n_in = 4'($urandom);
      while (!fin && cyc < 200) begin
         cyc++;
         start = 0;
         if (sym == n) begin
            got_s = {out_valid, done, busy, out_last, sum_total};
            exp_s = {1'b0, 1'b1, 1'b1, 1'b0, 10'(sum)};
            n_checks++;
            if (got_s !== exp_s) begin
               n_fail++;
               $display("FAIL %s done-cycle {v,d,b,l,sum} got=%h exp=%h", name, got_s, exp_s);
            end
            if (stall_mode == 0) begin
               n_checks++;
               if (cyc != n + 1) begin
                  n_fail++;
                  $display("FAIL %s done-latency got=%0d exp=%0d", name, cyc, n + 1);
               end
            end
            fin = 1;
         end else begin
            got = {out_valid, done, busy, out_last, out_sym, out_weight, sum_total};
            exp = {1'b1, 1'b0, 1'b1, sym == n - 1, 4'(sym), 6'(4 * (n - sym)), 10'(sum)};
            n_checks++;
            if (got !== exp) begin
               n_fail++;
               $display("FAIL %s beat cyc=%0d {v,d,b,l,sym,w,sum} got=%h exp=%h", name, cyc, got, exp);
            end
            if (pulse_start && !pulsed && sym == 2) begin
               start = 1; n_in = 2; pulsed = 1;
            end
            out_ready = (stall_mode < 0) ? (cyc % 3 == 1) : ($urandom_range(99) >= stall_mode);
            if (out_ready) begin
               sum += 4 * (n - sym);
               sym++;
            end
         end
         @(negedge clk);
      end
      start = 0;
      if (!fin) begin
         n_checks++; n_fail++;
         $display("FAIL %s timeout got=no-done exp=done", name);
      end
      for (int i = 0; i < 3; i++) begin
         got_s = {out_valid, done, busy, out_last, sum_total};
         exp_s = {4'b0, 10'(sum)};
         n_checks++;
         if (got_s !== exp_s) begin
            n_fail++;
            $display("FAIL %s idle+%0d {v,d,b,l,sum} got=%h exp=%h", name, i, got_s, exp_s);
         end
         out_ready = 1'($urandom);
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      logic [23:0] got;
      rst = 1; out_ready = 1; start = 1; n_in = 7;
      repeat (3) @(negedge clk);
      got = {out_valid, done, busy, out_last, out_sym, out_weight, sum_total};
      n_checks++;
      if (got !== 24'h0) begin
         n_fail++;
         $display("FAIL reset-values got=%h exp=%h", got, 24'h0);
      end
      rst = 0; start = 0; n_in = 0;
   endtask

   task automatic test_basic();        run_frame(3, 0, 0, "basic");            endtask
   task automatic test_full();         run_frame(15, 0, 0, "full");            endtask
   task automatic test_empty();        run_frame(0, 0, 0, "empty");            endtask
   task automatic test_backpressure(); run_frame(4, -1, 0, "backpressure");    endtask

   task automatic test_start_busy();
      run_frame(5, 0, 1, "start-busy");
      run_frame(2, 0, 0, "start-after");
   endtask

   task automatic test_reset_mid();
      logic [23:0] got;
      @(negedge clk);
      start = 1; n_in = 6; out_ready = 1;
      @(negedge clk);
      start = 0;
      @(negedge clk);
      n_checks++;
      if ({out_valid, out_sym} !== {1'b1, 4'd1}) begin
         n_fail++;
         $display("FAIL reset-mid beat1 {v,sym} got=%h exp=%h", {out_valid, out_sym}, {1'b1, 4'd1});
      end
      rst = 1;
      @(negedge clk);
      rst = 0;
      got = {out_valid, done, busy, out_last, out_sym, out_weight, sum_total};
      n_checks++;
      if (got !== 24'h0) begin
         n_fail++;
         $display("FAIL reset-mid values got=%h exp=%h", got, 24'h0);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_checks++;
         if ({done, out_valid, busy} !== 3'b0) begin
            n_fail++;
            $display("FAIL reset-mid quiet {d,v,b} got=%b exp=000", {done, out_valid, busy});
         end
      end
      run_frame(1, 0, 0, "reset-mid-n1");
   endtask

   task automatic test_random();
      for (int i = 0; i < 25; i++) run_frame($urandom_range(15), $urandom_range(60), 1'($urandom), "random");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full();
      test_empty();
      test_backpressure();
      test_start_busy();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
